// File: rtl/vga_pkg.sv
// vga_pkg: shared types and constants for the
// VGA pixel output pipe.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_VIDEO = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_RAMP  = 2'd3
    } mode_e;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

    localparam rgb565_t BAR_WHITE   = 16'hFFFF;
    localparam rgb565_t BAR_YELLOW  = 16'hFFE0;
    localparam rgb565_t BAR_CYAN    = 16'h07FF;
    localparam rgb565_t BAR_GREEN   = 16'h07E0;
    localparam rgb565_t BAR_MAGENTA = 16'hF81F;
    localparam rgb565_t BAR_RED     = 16'hF800;
    localparam rgb565_t BAR_BLUE    = 16'h001F;
    localparam rgb565_t BAR_BLACK   = 16'h0000;

    function automatic rgb565_t bar_rgb(
        input logic [2:0] idx
    );
        rgb565_t c;
        unique case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_pixel_pipe_if.sv
// vga_pixel_pipe_if: sync-generator, frame-FIFO and
// pin-side signals of the VGA pixel pipe.
interface vga_pixel_pipe_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic              Ready_Sig;
    logic [ADDR_W-1:0] Column_Addr_Sig;
    logic [ADDR_W-1:0] Row_Addr_Sig;
    logic [1:0]        Mode_Sel;
    logic              fifo_empty;
    logic [DATA_W-1:0] display_data;
    logic              underflow_clr;
    logic              fifo_rd_en;
    logic [4:0]        Red_Sig;
    logic [5:0]        Green_Sig;
    logic [4:0]        Blue_Sig;
    logic              frame_start;
    logic              underflow_flag;
    logic [15:0]       underflow_cnt;

    modport master (
        output Ready_Sig, Column_Addr_Sig,
        output Row_Addr_Sig, Mode_Sel,
        output fifo_empty, display_data,
        output underflow_clr,
        input  fifo_rd_en, Red_Sig,
        input  Green_Sig, Blue_Sig,
        input  frame_start, underflow_flag,
        input  underflow_cnt
    );

    modport slave (
        input  Ready_Sig, Column_Addr_Sig,
        input  Row_Addr_Sig, Mode_Sel,
        input  fifo_empty, display_data,
        input  underflow_clr,
        output fifo_rd_en, Red_Sig,
        output Green_Sig, Blue_Sig,
        output frame_start, underflow_flag,
        output underflow_cnt
    );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: fixed-depth shift register with
// synchronous clear of every stage.
module vga_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++)
                stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++)
                stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[DEPTH-1];
endmodule

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe: window decode, FIFO read strobe,
// latency alignment and registered RGB565 output.
module vga_pixel_pipe
    import vga_pkg::*;
#(
    parameter int          ADDR_W     = 11,
    parameter int          H_START    = 1,
    parameter int          H_ACT      = 800,
    parameter int          V_START    = 1,
    parameter int          V_ACT      = 600,
    parameter int          DATA_W     = 16,
    parameter int          RD_LAT     = 1,
    parameter logic [15:0] BORDER_RGB = 16'h0000
) (
    input logic        CLK,
    input logic        RST,
    vga_pixel_pipe_if.slave bus
);
    localparam int LW    = ADDR_W + 4;
    localparam int BAR_W = H_ACT / 8;
    localparam logic [ADDR_W:0] H_LO =
        (ADDR_W+1)'(H_START);
    localparam logic [ADDR_W:0] H_HI =
        (ADDR_W+1)'(H_START + H_ACT);
    localparam logic [ADDR_W:0] V_LO =
        (ADDR_W+1)'(V_START);
    localparam logic [ADDR_W:0] V_HI =
        (ADDR_W+1)'(V_START + V_ACT);

    logic [ADDR_W:0] col_x, row_x;
    logic            h_act, v_act;
    logic            in_win, rd_en;
    mode_e           mode_q, mode_d;

    assign col_x  = {1'b0, bus.Column_Addr_Sig};
    assign row_x  = {1'b0, bus.Row_Addr_Sig};
    assign h_act  = (col_x >= H_LO) && (col_x < H_HI);
    assign v_act  = (row_x >= V_LO) && (row_x < V_HI);
    assign in_win = bus.Ready_Sig && h_act && v_act;

    // Mode only follows Mode_Sel during vertical blanking.
    assign mode_d = v_act ? mode_q
                          : mode_e'(bus.Mode_Sel);
    assign rd_en  = in_win && (mode_q == MODE_VIDEO)
                    && !RST;
    assign bus.fifo_rd_en = rd_en;

    logic [ADDR_W-1:0] offset;
    logic [LW-1:0]     dl_in, dl_out;

    assign offset = bus.Column_Addr_Sig
                    - H_LO[ADDR_W-1:0];
    assign dl_in  = {bus.Ready_Sig, in_win, rd_en,
                     bus.fifo_empty, offset};

    vga_delay_line #(
        .DEPTH (RD_LAT),
        .WIDTH (LW)
    ) u_dly (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (dl_in),
        .q_o   (dl_out)
    );

    logic              t_rdy, t_win, t_rd, t_emp;
    logic [ADDR_W-1:0] t_off;

    assign {t_rdy, t_win, t_rd, t_emp, t_off} = dl_out;

    rgb565_t vid;
    if (DATA_W == 24) begin : g_888
        logic unused_lsb;
        assign vid = {bus.display_data[23:19],
                      bus.display_data[15:10],
                      bus.display_data[7:3]};
        assign unused_lsb = ^{bus.display_data[18:16],
                              bus.display_data[9:8],
                              bus.display_data[2:0]};
    end else begin : g_565
        assign vid = bus.display_data[15:0];
    end

    logic [5:0] ramp;
    if (ADDR_W >= 10) begin : g_ramp
        assign ramp = t_off[9:4];
    end else begin : g_ramp_nx
        assign ramp = 6'({10'd0, t_off} >> 4);
    end

    logic [ADDR_W-1:0] bar_n;
    logic [2:0]        bar_idx;

    assign bar_n   = t_off / ADDR_W'(BAR_W);
    assign bar_idx = (bar_n > ADDR_W'(7)) ? 3'd7
                                          : bar_n[2:0];

    rgb565_t pix_d, pix_q, border;
    logic    uf;

    assign border = rgb565_t'(BORDER_RGB);

    always_comb begin
        pix_d = '0;
        uf    = 1'b0;
        unique case (1'b1)
            !t_rdy:          pix_d = '0;
            t_rdy && !t_win: pix_d = border;
            t_win && t_rd: begin
                pix_d = t_emp ? border : vid;
                uf    = t_emp;
            end
            t_win && !t_rd: begin
                unique case (mode_q)
                    MODE_BARS: pix_d = bar_rgb(bar_idx);
                    MODE_RAMP: pix_d = {ramp[5:1], ramp,
                                        ramp[5:1]};
                    default:   pix_d = border;
                endcase
            end
            default:         pix_d = '0;
        endcase
    end

    logic        uf_flag_q, uf_flag_d;
    logic [15:0] uf_cnt_q, uf_cnt_d;
    logic        fs_q, fs_d;

    always_comb begin
        uf_flag_d = uf_flag_q;
        uf_cnt_d  = uf_cnt_q;
        if (bus.underflow_clr) begin
            uf_flag_d = 1'b0;
            uf_cnt_d  = '0;
        end else if (uf) begin
            uf_flag_d = 1'b1;
            if (uf_cnt_q != 16'hFFFF)
                uf_cnt_d = uf_cnt_q + 16'd1;
        end
    end

    assign fs_d = bus.Ready_Sig && (col_x == H_LO)
                  && (row_x == V_LO);

    always_ff @(posedge CLK) begin
        if (RST) begin
            mode_q    <= MODE_VIDEO;
            pix_q     <= '0;
            fs_q      <= 1'b0;
            uf_flag_q <= 1'b0;
            uf_cnt_q  <= '0;
        end else begin
            mode_q    <= mode_d;
            pix_q     <= pix_d;
            fs_q      <= fs_d;
            uf_flag_q <= uf_flag_d;
            uf_cnt_q  <= uf_cnt_d;
        end
    end

    assign bus.Red_Sig        = pix_q.r;
    assign bus.Green_Sig      = pix_q.g;
    assign bus.Blue_Sig       = pix_q.b;
    assign bus.frame_start    = fs_q;
    assign bus.underflow_flag = uf_flag_q;
    assign bus.underflow_cnt  = uf_cnt_q;
endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe: directed and random checks of two
// vga_pixel_pipe configurations against a cycle model.
module tb_vga_pixel_pipe;
    typedef struct {
        bit rdy;
        bit win;
        bit rd;
        bit emp;
        int off;
    } rec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    vga_pixel_pipe_if #(.ADDR_W(11), .DATA_W(16)) if0 ();
    vga_pixel_pipe_if #(.ADDR_W(11), .DATA_W(24)) if1 ();

    vga_pixel_pipe u0 (
        .CLK (clk),
        .RST (rst),
        .bus (if0)
    );

    vga_pixel_pipe #(
        .ADDR_W     (11),
        .H_START    (4),
        .H_ACT      (64),
        .V_START    (2),
        .V_ACT      (8),
        .DATA_W     (24),
        .RD_LAT     (3),
        .BORDER_RGB (16'h1234)
    ) u1 (
        .CLK (clk),
        .RST (rst),
        .bus (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hs(int k);
        return (k == 0) ? 1 : 4;
    endfunction
    function automatic int ha(int k);
        return (k == 0) ? 800 : 64;
    endfunction
    function automatic int vs(int k);
        return (k == 0) ? 1 : 2;
    endfunction
    function automatic int va(int k);
        return (k == 0) ? 600 : 8;
    endfunction
    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction
    function automatic int brd(int k);
        return (k == 0) ? 0 : 'h1234;
    endfunction

    rec_t hist [2][4];
    int   m_mode [2];
    bit   m_flag [2];
    int   m_cnt  [2];
    int   e_r [2], e_g [2], e_b [2];
    bit   e_fs [2];

    task automatic chk(input string tag, input int k,
                       input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d got %0d want %0d",
                   tag, k, obs, exp);
        end
    endtask

    task automatic set_pix(input int k, input int c);
        e_r[k] = (c >> 11) & 31;
        e_g[k] = (c >> 5) & 63;
        e_b[k] = c & 31;
    endtask

    task automatic model(input int k, input bit rdy,
                         input int col, input int row,
                         input int mode, input bit emp,
                         input bit clr, input bit rs,
                         input logic [23:0] d);
        rec_t t;
        bit   win, rd, uf;
        int   dv, idx;
        win = rdy && col >= hs(k) && col < hs(k) + ha(k)
              && row >= vs(k) && row < vs(k) + va(k);
        rd  = !rs && win && m_mode[k] == 0;
        chk("rd_en", k, (k == 0) ? int'(if0.fifo_rd_en)
                                 : int'(if1.fifo_rd_en),
            int'(rd));
        if (rs) begin
            set_pix(k, 0);
            e_fs[k]   = 0;
            m_flag[k] = 0;
            m_cnt[k]  = 0;
            m_mode[k] = 0;
            for (int i = 0; i < 4; i++)
                hist[k][i] = '{0, 0, 0, 0, 0};
            return;
        end
        t  = hist[k][lat(k) - 1];
        uf = 0;
        if (!t.rdy) set_pix(k, 0);
        else if (!t.win) set_pix(k, brd(k));
        else if (t.rd && t.emp) begin
            set_pix(k, brd(k));
            uf = 1;
        end else if (t.rd) begin
            if (k == 0) begin
                set_pix(k, int'(d[15:0]));
            end else begin
                dv = int'(d);
                e_r[k] = (dv >> 19) & 31;
                e_g[k] = (dv >> 10) & 63;
                e_b[k] = (dv >> 3) & 31;
            end
        end else if (m_mode[k] == 1) begin
            idx = t.off / (ha(k) / 8);
            if (idx > 7) idx = 7;
            e_r[k] = (idx % 4 < 2) ? 31 : 0;
            e_g[k] = (idx < 4) ? 63 : 0;
            e_b[k] = (idx % 2 == 0) ? 31 : 0;
        end else if (m_mode[k] == 3) begin
            e_r[k] = (t.off >> 5) & 31;
            e_g[k] = (t.off >> 4) & 63;
            e_b[k] = e_r[k];
        end else set_pix(k, brd(k));
        if (clr) begin
            m_flag[k] = 0;
            m_cnt[k]  = 0;
        end else if (uf) begin
            m_flag[k] = 1;
            if (m_cnt[k] < 65535) m_cnt[k]++;
        end
        e_fs[k] = rdy && col == hs(k) && row == vs(k);
        for (int i = 3; i > 0; i--)
            hist[k][i] = hist[k][i-1];
        hist[k][0] = '{rdy, win, rd, emp,
                       (col - hs(k)) & 'h7FF};
        if (row < vs(k) || row >= vs(k) + va(k))
            m_mode[k] = mode;
    endtask

    task automatic step(input bit rdy, input int col,
                        input int row, input int mode,
                        input bit emp, input bit clr,
                        input bit rs,
                        input logic [23:0] d);
        @(negedge clk);
        rst = rs;
        if0.Ready_Sig       = rdy;
        if1.Ready_Sig       = rdy;
        if0.Column_Addr_Sig = 11'(col);
        if1.Column_Addr_Sig = 11'(col);
        if0.Row_Addr_Sig    = 11'(row);
        if1.Row_Addr_Sig    = 11'(row);
        if0.Mode_Sel        = 2'(mode);
        if1.Mode_Sel        = 2'(mode);
        if0.fifo_empty      = emp;
        if1.fifo_empty      = emp;
        if0.underflow_clr   = clr;
        if1.underflow_clr   = clr;
        if0.display_data    = d[15:0];
        if1.display_data    = d;
        #1;
        for (int k = 0; k < 2; k++)
            model(k, rdy, col, row, mode, emp, clr, rs, d);
        @(posedge clk);
        #1;
        chk("red", 0, int'(if0.Red_Sig), e_r[0]);
        chk("green", 0, int'(if0.Green_Sig), e_g[0]);
        chk("blue", 0, int'(if0.Blue_Sig), e_b[0]);
        chk("fs", 0, int'(if0.frame_start), int'(e_fs[0]));
        chk("uf_flag", 0, int'(if0.underflow_flag),
            int'(m_flag[0]));
        chk("uf_cnt", 0, int'(if0.underflow_cnt), m_cnt[0]);
        chk("red", 1, int'(if1.Red_Sig), e_r[1]);
        chk("green", 1, int'(if1.Green_Sig), e_g[1]);
        chk("blue", 1, int'(if1.Blue_Sig), e_b[1]);
        chk("fs", 1, int'(if1.frame_start), int'(e_fs[1]));
        chk("uf_flag", 1, int'(if1.underflow_flag),
            int'(m_flag[1]));
        chk("uf_cnt", 1, int'(if1.underflow_cnt), m_cnt[1]);
    endtask

    task automatic walk(input int row, input int c0,
                        input int c1, input int mode,
                        input bit emp,
                        input logic [23:0] d);
        for (int c = c0; c <= c1; c++)
            step(1, c, row, mode, emp, 0, 0, d);
    endtask

    initial begin
        int col, row, sel;
        int offs [5];
        rst = 1'b1;
        repeat (3) step(0, 0, 0, 0, 0, 0, 1, 24'h0);

        // video, never empty, red
        step(1, 0, 0, 0, 0, 0, 0, 24'h00F800);
        walk(1, 0, 4, 0, 0, 24'h00F800);
        chk("red_f800", 0, int'(if0.Red_Sig), 31);
        walk(1, 798, 803, 0, 0, 24'h00F800);
        walk(600, 798, 801, 0, 0, 24'h00F800);
        walk(601, 3, 5, 0, 0, 24'h00F800);
        chk("row601_border", 0, int'(if0.Red_Sig), 0);

        // five underflows then clear
        walk(5, 10, 14, 0, 1, 24'h00F800);
        walk(5, 15, 16, 0, 0, 24'h00F800);
        chk("uf_cnt5", 0, int'(if0.underflow_cnt), 5);
        chk("uf_flag1", 0, int'(if0.underflow_flag), 1);
        step(1, 17, 5, 0, 0, 1, 0, 24'h00F800);
        chk("uf_clr", 0, int'(if0.underflow_cnt), 0);

        // colour bars
        step(1, 0, 0, 1, 0, 0, 0, 24'h0);
        offs = '{0, 100, 799, 99, 700};
        step(1, offs[0] + 1, 5, 1, 0, 0, 0, 24'h0);
        step(1, offs[1] + 1, 5, 1, 0, 0, 0, 24'h0);
        chk("bar0_b", 0, int'(if0.Blue_Sig), 31);
        step(1, offs[2] + 1, 5, 1, 0, 0, 0, 24'h0);
        chk("bar1_b", 0, int'(if0.Blue_Sig), 0);
        chk("bar1_g", 0, int'(if0.Green_Sig), 63);
        step(1, offs[3] + 1, 5, 1, 0, 0, 0, 24'h0);
        chk("bar7_g", 0, int'(if0.Green_Sig), 0);
        step(1, offs[4] + 1, 5, 1, 0, 0, 0, 24'h0);
        for (int o = 0; o < 800; o += 50)
            step(1, o + 1, 7, 1, 0, 0, 0, 24'h0);
        step(0, 0, 7, 1, 0, 0, 0, 24'h0);

        // grey ramp
        step(1, 0, 0, 3, 0, 0, 0, 24'h0);
        for (int o = 0; o < 800; o += 37)
            step(1, o + 1, 9, 3, 0, 0, 0, 24'h0);

        // mode change mid-frame waits for blanking
        step(1, 0, 0, 0, 0, 0, 0, 24'h00F800);
        walk(300, 1, 5, 1, 0, 24'h00F800);
        chk("midframe_video", 0, int'(if0.Red_Sig), 31);
        walk(600, 799, 800, 1, 0, 24'h00F800);
        step(1, 0, 601, 1, 0, 0, 0, 24'h00F800);
        step(1, 1, 1, 1, 0, 0, 0, 24'h00F800);
        chk("fs_pulse", 0, int'(if0.frame_start), 1);
        walk(1, 2, 4, 1, 0, 24'h00F800);
        chk("bars_next", 0, int'(if0.Blue_Sig), 31);

        // 24-bit data through three-deep delay
        step(1, 0, 0, 0, 0, 0, 0, 24'h0);
        repeat (5) step(1, 10, 3, 0, 0, 0, 0, 24'h80FF01);
        chk("rgb888_r", 1, int'(if1.Red_Sig), 16);
        chk("rgb888_g", 1, int'(if1.Green_Sig), 63);
        chk("rgb888_b", 1, int'(if1.Blue_Sig), 0);

        // reset mid-row
        walk(5, 30, 33, 0, 1, 24'h00F800);
        step(1, 34, 5, 0, 0, 0, 1, 24'h00F800);
        step(1, 35, 5, 0, 0, 0, 1, 24'h00F800);
        chk("rst_rd", 0, int'(if0.fifo_rd_en), 0);
        walk(5, 36, 42, 0, 0, 24'h00F800);
        chk("rst_cnt", 0, int'(if0.underflow_cnt), 0);

        // random traffic
        col = 0;
        row = 0;
        repeat (4000) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: begin
                    col = $urandom_range(0, 820);
                    row = $urandom_range(0, 605);
                end
                1: begin
                    col = $urandom_range(0, 72);
                    row = $urandom_range(0, 12);
                end
                2: col = col + 1;
                default:
                    row = ($urandom_range(0, 1) == 1)
                          ? 0 : 601;
            endcase
            if (col > 1023) col = 0;
            step($urandom_range(0, 7) != 0, col, row,
                 $urandom_range(0, 3),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 199) == 0,
                 24'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
